// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: command opcodes and frame-parse states.
package uart_cmd_pkg;

    localparam logic [7:0] CmdRfWr    = 8'hAA;
    localparam logic [7:0] CmdRfRd    = 8'hBB;
    localparam logic [7:0] CmdAluOp   = 8'hCC;
    localparam logic [7:0] CmdAluNoOp = 8'hDD;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StAluOpa,
        StAluOpb,
        StAluFun
    } state_e;

endpackage

// File: rtl/frame_timer.sv
// Mid-frame idle counter; expired is asserted while the count equals TIMEOUT.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

    logic [CntWidth-1:0] r_cnt;

    // Saturate at TIMEOUT so the count never wraps while waiting for the clear.
    always_ff @(posedge clk) begin
        if (RST || clr) begin
            r_cnt <= '0;
        end else if (run && !expired) begin
            r_cnt <= r_cnt + CntWidth'(1);
        end
    end

    assign expired = (r_cnt == CntWidth'(TIMEOUT));

endmodule

// File: rtl/rx_cmd_decoder.sv
// Decodes framed UART command bytes into register-file and ALU strobes.
module rx_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CMD_ERR,
    output logic                  FRM_ERR
);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  w_expired;
    logic                  w_clr;
    logic                  w_run;

    // Any accepted byte restarts the idle window, so a byte on the expiry cycle wins.
    assign w_clr = (r_state == StIdle) || RX_D_VLD;
    assign w_run = !w_clr;

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .clk     (clk),
        .RST     (RST),
        .clr     (w_clr),
        .run     (w_run),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= StIdle;
            r_wr_addr  <= '0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            ALU_FUN    <= '0;
            ALU_EN     <= 1'b0;
            CMD_ERR    <= 1'b0;
            FRM_ERR    <= 1'b0;
        end else begin
            RF_WrEn <= 1'b0;
            RF_RdEn <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;
            FRM_ERR <= 1'b0;
            if (RX_D_VLD) begin
                unique case (r_state)
                    StIdle: begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(CmdRfWr):    r_state <= StWrAddr;
                            DATA_WIDTH'(CmdRfRd):    r_state <= StRdAddr;
                            DATA_WIDTH'(CmdAluOp):   r_state <= StAluOpa;
                            DATA_WIDTH'(CmdAluNoOp): r_state <= StAluFun;
                            default:                 CMD_ERR <= 1'b1;
                        endcase
                    end
                    StWrAddr: begin
                        r_wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state   <= StWrData;
                    end
                    StWrData: begin
                        RF_Address <= r_wr_addr;
                        RF_WrData  <= RX_P_DATA;
                        RF_WrEn    <= 1'b1;
                        r_state    <= StIdle;
                    end
                    StRdAddr: begin
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RdEn    <= 1'b1;
                        r_state    <= StIdle;
                    end
                    StAluOpa: begin
                        RF_Address <= '0;
                        RF_WrData  <= RX_P_DATA;
                        RF_WrEn    <= 1'b1;
                        r_state    <= StAluOpb;
                    end
                    StAluOpb: begin
                        RF_Address <= ADDR_WIDTH'(1);
                        RF_WrData  <= RX_P_DATA;
                        RF_WrEn    <= 1'b1;
                        r_state    <= StAluFun;
                    end
                    StAluFun: begin
                        ALU_FUN <= RX_P_DATA[3:0];
                        ALU_EN  <= 1'b1;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end else if (w_expired && (r_state != StIdle)) begin
                r_state <= StIdle;
                FRM_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed scoreboard bench for rx_cmd_decoder: expected strobes are queued when bytes are driven.
module tb_rx_cmd_decoder;

    localparam int unsigned TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic       RF_WrEn;
    logic       RF_RdEn;
    logic [3:0] ALU_FUN;
    logic       ALU_EN;
    logic       CMD_ERR;
    logic       FRM_ERR;

    rx_cmd_decoder #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RF_Address (RF_Address),
        .RF_WrData  (RF_WrData),
        .RF_WrEn    (RF_WrEn),
        .RF_RdEn    (RF_RdEn),
        .ALU_FUN    (ALU_FUN),
        .ALU_EN     (ALU_EN),
        .CMD_ERR    (CMD_ERR),
        .FRM_ERR    (FRM_ERR)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {FRM_ERR, CMD_ERR, ALU_EN, RF_RdEn, RF_WrEn}
    localparam logic [4:0] KWr  = 5'b00001;
    localparam logic [4:0] KRd  = 5'b00010;
    localparam logic [4:0] KAlu = 5'b00100;
    localparam logic [4:0] KCmd = 5'b01000;
    localparam logic [4:0] KFrm = 5'b10000;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  kind;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [3:0]  fun;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    // Model of the held output fields.
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [3:0] m_fun = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at the negedge where the frame's last byte is driven: strobe due one edge later.
    task automatic push(input logic [4:0] kind);
        ev_t e;
        e.cyc   = cyc + 1;
        e.kind  = kind;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        e.fun   = m_fun;
        sb.push_back(e);
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        m_addr  = a;
        m_wdata = d;
        push(KWr);
    endtask

    task automatic exp_rd(input logic [3:0] a);
        m_addr = a;
        push(KRd);
    endtask

    task automatic exp_alu(input logic [3:0] f);
        m_fun = f;
        push(KAlu);
    endtask

    task automatic send(input logic [7:0] b);
        RX_D_VLD  = 1'b1;
        RX_P_DATA = b;
        @(negedge clk);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(RF_Address), 32'h0);
        check({tag, "_wdata"}, 32'(RF_WrData), 32'h0);
        check({tag, "_fun"}, 32'(ALU_FUN), 32'h0);
        check({tag, "_strobes"}, 32'({FRM_ERR, CMD_ERR, ALU_EN, RF_RdEn, RF_WrEn}), 32'h0);
    endtask

    always @(negedge clk) begin
        logic [4:0] obs;
        ev_t        e;
        obs = {FRM_ERR, CMD_ERR, ALU_EN, RF_RdEn, RF_WrEn};
        if (obs !== 5'b0 && !RST) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(obs), 32'h0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'(obs), 32'(e.kind));
                check("strobe_cycle", cyc, e.cyc);
                check("rf_address", 32'(RF_Address), 32'(e.addr));
                check("rf_wrdata", 32'(RF_WrData), 32'(e.wdata));
                check("alu_fun", 32'(ALU_FUN), 32'(e.fun));
            end
        end
    end

    initial begin
        int unsigned k;
        RST       = 1'b1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
        idle(3);
        check_all_zero("reset");
        RST = 1'b0;
        idle(2);

        // RF write
        send(8'hAA);
        send(8'h05);
        exp_wr(4'h5, 8'h3C);
        send(8'h3C);
        idle(3);

        // RF read; write data must hold
        send(8'hBB);
        exp_rd(4'hF);
        send(8'h0F);
        idle(3);

        // ALU with operands
        send(8'hCC);
        exp_wr(4'h0, 8'h12);
        send(8'h12);
        exp_wr(4'h1, 8'h34);
        send(8'h34);
        exp_alu(4'h2);
        send(8'h02);
        idle(3);

        // Unknown command, then ALU without operands
        push(KCmd);
        send(8'h7E);
        idle(2);
        send(8'hDD);
        exp_alu(4'h8);
        send(8'h08);
        idle(3);

        // Timeout: 1024 idle cycles after the address byte aborts the frame
        send(8'hAA);
        k = cyc;
        sb.push_back('{cyc: k + TIMEOUT + 2, kind: KFrm, addr: m_addr, wdata: m_wdata,
                       fun: m_fun});
        send(8'h03);
        idle(TIMEOUT + 5);

        // Data byte lands exactly on the expiry cycle: it wins
        send(8'hAA);
        send(8'h03);
        idle(TIMEOUT);
        exp_wr(4'h3, 8'h77);
        send(8'h77);
        idle(TIMEOUT + 10);

        // Reset mid-frame discards the partial write
        send(8'hAA);
        send(8'h03);
        RST = 1'b1;
        idle(2);
        check_all_zero("midreset");
        RST     = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_fun   = '0;
        send(8'hBB);
        exp_rd(4'h1);
        send(8'h01);
        idle(3);

        // Back-to-back frames
        send(8'hAA);
        send(8'h01);
        exp_wr(4'h1, 8'h55);
        send(8'h55);
        send(8'hAA);
        send(8'h02);
        exp_wr(4'h2, 8'h66);
        send(8'h66);
        idle(5);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
